// File: rtl/bnn_pkg.sv
// bnn_pkg: shared constants, index widths and scheduler state type for the BNN conv stage
package bnn_pkg;
  localparam int IMG_DIM = 28;
  localparam int K_DIM = 3;
  localparam int N_FILT = 8;
  localparam int OUT_DIM = IMG_DIM - K_DIM + 1;
  localparam int FW = $clog2(N_FILT);
  localparam int RW = $clog2(OUT_DIM);
  typedef enum logic [2:0] {IDLE, WAIT_LOAD, RUN, DRAIN, DONE} sched_state_t;
endpackage

// File: rtl/xnor_popcount9.sv
// xnor_popcount9: combinational XNOR-popcount of a 3x3 binary window against a 3x3 binary kernel
//   i_win [8:0] window bits, i_ker [8:0] kernel bits (same bit pairing), o_pop [3:0] matches 0..9
module xnor_popcount9 (
  input  logic [8:0] i_win,
  input  logic [8:0] i_ker,
  output logic [3:0] o_pop
);
  logic [8:0] w_match;
  assign w_match = ~(i_win ^ i_ker);
  always_comb begin
    o_pop = '0;
    for (int k = 0; k < 9; k++) o_pop = o_pop + {3'b000, w_match[k]};
  end
endmodule

// File: rtl/bnn_conv_sched.sv
// bnn_conv_sched: walks every 3x3 window per filter, emits thresholded XNOR-popcounts on a valid/ready stream
//   clk, reset_n (async, active-low); start/abort/load_done control; pixels[r][c], weights[f][i][j] data in;
//   out_valid/out_ready handshake with out_bit, out_pop, out_f, out_r, out_c; busy (not IDLE), done (1-cycle pulse)
module bnn_conv_sched #(
  parameter int IMG_DIM = bnn_pkg::IMG_DIM,
  parameter int K_DIM = bnn_pkg::K_DIM,
  parameter int N_FILT = bnn_pkg::N_FILT,
  parameter int THRESH = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     load_done,
  input  logic [IMG_DIM-1:0]       pixels [0:IMG_DIM-1],
  input  logic [2:0][2:0]          weights [0:N_FILT-1],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_bit,
  output logic [3:0]               out_pop,
  output logic [bnn_pkg::FW-1:0]   out_f,
  output logic [bnn_pkg::RW-1:0]   out_r,
  output logic [bnn_pkg::RW-1:0]   out_c,
  output logic                     busy,
  output logic                     done
);
  import bnn_pkg::*;
  localparam logic [RW-1:0] LAST = RW'(IMG_DIM - K_DIM);
  localparam logic [FW-1:0] FLAST = FW'(N_FILT - 1);
  sched_state_t r_st, w_nst;
  logic [FW-1:0] r_f;
  logic [RW-1:0] r_r, r_c;
  logic [8:0] w_win, w_ker;
  logic [3:0] w_pop;
  logic w_abort, w_adv, w_hs, w_cw, w_rw, w_last;
  for (genvar i = 0; i < 3; i++) begin : g_row
    for (genvar j = 0; j < 3; j++) begin : g_col
      assign w_win[i*3+j] = pixels[r_r + RW'(i)][r_c + RW'(j)];
      assign w_ker[i*3+j] = weights[r_f][i][j];
    end
  end
  xnor_popcount9 u_pop (.i_win(w_win), .i_ker(w_ker), .o_pop(w_pop));
  assign w_abort = abort && (r_st != IDLE);
  // Issue whenever the output register is empty or drains this cycle.
  assign w_adv = (r_st == RUN) && (!out_valid || out_ready);
  assign w_hs = out_valid && out_ready;
  assign w_cw = r_c == LAST;
  assign w_rw = r_r == LAST;
  assign w_last = w_cw && w_rw && (r_f == FLAST);
  assign busy = r_st != IDLE;
  assign done = r_st == DONE;
  always_comb begin
    w_nst = r_st;
    if (w_abort) w_nst = IDLE;
    else
      case (r_st)
        IDLE:      w_nst = start ? (load_done ? RUN : WAIT_LOAD) : IDLE;
        WAIT_LOAD: w_nst = load_done ? RUN : WAIT_LOAD;
        RUN:       w_nst = (w_adv && w_last) ? DRAIN : RUN;
        DRAIN:     w_nst = w_hs ? DONE : DRAIN;
        default:   w_nst = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_st <= IDLE;
      r_f <= '0;
      r_r <= '0;
      r_c <= '0;
      out_valid <= 1'b0;
      out_bit <= 1'b0;
      out_pop <= '0;
      out_f <= '0;
      out_r <= '0;
      out_c <= '0;
    end else begin
      r_st <= w_nst;
      if (w_abort) begin
        out_valid <= 1'b0;
        r_f <= '0;
        r_r <= '0;
        r_c <= '0;
      end else if (w_adv) begin
        out_valid <= 1'b1;
        out_bit <= w_pop >= 4'(THRESH);
        out_pop <= w_pop;
        out_f <= r_f;
        out_r <= r_r;
        out_c <= r_c;
        r_c <= w_cw ? '0 : r_c + 1'b1;
        r_r <= w_cw ? (w_rw ? '0 : r_r + 1'b1) : r_r;
        r_f <= (w_cw && w_rw) ? ((r_f == FLAST) ? '0 : r_f + 1'b1) : r_f;
      end else if (out_ready) out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_bnn_conv_sched.sv
// tb_bnn_conv_sched: scoreboard bench for the BNN convolution scheduler
module tb_bnn_conv_sched;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic load_done = 1'b0;
  logic out_ready = 1'b0;
  logic [27:0] px [0:27];
  logic [2:0][2:0] wt [0:7];
  logic out_valid, out_bit, busy, done;
  logic [3:0] out_pop;
  logic [2:0] out_f;
  logic [4:0] out_r, out_c;
  logic [17:0] q[$];
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  bnn_conv_sched dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .load_done(load_done),
    .pixels(px), .weights(wt), .out_valid(out_valid), .out_ready(out_ready),
    .out_bit(out_bit), .out_pop(out_pop), .out_f(out_f), .out_r(out_r), .out_c(out_c),
    .busy(busy), .done(done)
  );
  wire [17:0] cur = {out_bit, out_pop, out_f, out_r, out_c};
  wire [22:0] all_out = {out_valid, cur, busy, done, 2'b00};

  function automatic logic [17:0] model(int f, int r, int c);
    int p;
    p = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p += (px[r+i][c+j] == wt[f][i][j]) ? 1 : 0;
    return {(p >= 5) ? 1'b1 : 1'b0, 4'(p), 3'(f), 5'(r), 5'(c)};
  endfunction

  task automatic fill_q();
    q.delete();
    for (int f = 0; f < 8; f++)
      for (int r = 0; r < 26; r++)
        for (int c = 0; c < 26; c++) q.push_back(model(f, r, c));
  endtask

  task automatic set_img(input logic p, input logic w);
    for (int r = 0; r < 28; r++) px[r] = {28{p}};
    for (int f = 0; f < 8; f++) wt[f] = {9{w}};
  endtask

  task automatic set_rand();
    for (int r = 0; r < 28; r++) px[r] = 28'($urandom);
    for (int f = 0; f < 8; f++) wt[f] = 9'($urandom);
  endtask

  // Full pass: expected results are queued up front and popped on every handshake.
  task automatic stream(input string tag, input int pct, output logic [17:0] first_res, output logic [17:0] last_res);
    int cyc, got, first_v, hs_last, done_cyc;
    logic [17:0] prev, exp;
    bit stalled;
    cyc = 0; got = 0; first_v = -1; hs_last = -1; done_cyc = -1; stalled = 0; prev = '0;
    first_res = '0; last_res = '0;
    fill_q();
    @(negedge clk);
    start = 1'b1;
    load_done = 1'b1;
    out_ready = 1'b1;
    while (done_cyc < 0 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (stalled) begin
        n_chk++;
        if (cur !== prev || out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL %s stall_hold cyc=%0d got=%h valid=%b expected=%h", tag, cyc, cur, out_valid, prev);
        end
      end
      if (out_valid && first_v < 0) first_v = cyc;
      if (done) done_cyc = cyc;
      out_ready = ($urandom_range(99) < pct);
      if (out_valid && out_ready) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL %s extra_result got=%h expected=none", tag, cur);
        end else begin
          exp = q.pop_front();
          if (cur !== exp) begin
            n_fail++;
            $display("FAIL %s result#%0d got=%h expected=%h", tag, got, cur, exp);
          end
        end
        if (got == 0) first_res = cur;
        last_res = cur;
        got++;
        hs_last = cyc;
      end
      stalled = out_valid && !out_ready;
      prev = cur;
    end
    n_chk++;
    if (got != 5408 || q.size() != 0) begin
      n_fail++;
      $display("FAIL %s count got=%0d left=%0d expected=5408 left=0", tag, got, q.size());
    end
    n_chk++;
    if (done_cyc != hs_last + 1) begin
      n_fail++;
      $display("FAIL %s done_timing got=%0d expected=%0d", tag, done_cyc, hs_last + 1);
    end
    if (pct >= 100) begin
      n_chk++;
      if (first_v != 2 || done_cyc != 5410) begin
        n_fail++;
        $display("FAIL %s latency first=%0d done=%0d expected first=2 done=5410", tag, first_v, done_cyc);
      end
    end
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s post_done busy=%b done=%b expected 0 0", tag, busy, done);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    set_img(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    n_chk++;
    if (all_out !== '0) begin
      n_fail++;
      $display("FAIL reset_held got=%h expected=0", all_out);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (all_out !== '0) begin
      n_fail++;
      $display("FAIL reset_released got=%h expected=0", all_out);
    end
  endtask

  task automatic test_zeros();
    logic [17:0] fr, lr;
    set_img(1'b0, 1'b0);
    stream("zeros", 100, fr, lr);
    n_chk++;
    if (fr !== {1'b1, 4'd9, 3'd0, 5'd0, 5'd0}) begin
      n_fail++;
      $display("FAIL zeros_first got=%h expected=%h", fr, {1'b1, 4'd9, 3'd0, 5'd0, 5'd0});
    end
    n_chk++;
    if (lr !== {1'b1, 4'd9, 3'd7, 5'd25, 5'd25}) begin
      n_fail++;
      $display("FAIL zeros_last got=%h expected=%h", lr, {1'b1, 4'd9, 3'd7, 5'd25, 5'd25});
    end
  endtask

  task automatic test_ones();
    logic [17:0] fr, lr;
    set_img(1'b1, 1'b0);
    stream("ones", 100, fr, lr);
    n_chk++;
    if (fr !== {1'b0, 4'd0, 3'd0, 5'd0, 5'd0}) begin
      n_fail++;
      $display("FAIL ones_first got=%h expected=%h", fr, {1'b0, 4'd0, 3'd0, 5'd0, 5'd0});
    end
  endtask

  task automatic test_corner_pixel();
    logic [17:0] fr, lr;
    set_img(1'b0, 1'b0);
    px[0][0] = 1'b1;
    stream("corner", 100, fr, lr);
    n_chk++;
    if (fr !== {1'b1, 4'd8, 3'd0, 5'd0, 5'd0}) begin
      n_fail++;
      $display("FAIL corner_first got=%h expected=%h", fr, {1'b1, 4'd8, 3'd0, 5'd0, 5'd0});
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] fr, lr;
    set_rand();
    stream("backpressure", 30, fr, lr);
  endtask

  task automatic test_wait_load_abort();
    logic [17:0] exp;
    int got, cyc;
    set_rand();
    fill_q();
    @(negedge clk);
    start = 1'b1;
    load_done = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      n_chk++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL wait_load cyc=%0d busy=%b valid=%b expected busy=1 valid=0", i, busy, out_valid);
      end
      @(negedge clk);
    end
    load_done = 1'b1;
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_load_early valid=%b expected=0", out_valid);
    end
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b1 || cur !== q[0]) begin
      n_fail++;
      $display("FAIL wait_load_first valid=%b got=%h expected valid=1 %h", out_valid, cur, q[0]);
    end
    got = 0;
    cyc = 0;
    while (got < 1000 && cyc < 3000) begin
      if (out_valid && out_ready) begin
        exp = q.pop_front();
        n_chk++;
        if (cur !== exp) begin
          n_fail++;
          $display("FAIL abort_stream result#%0d got=%h expected=%h", got, cur, exp);
        end
        got++;
      end
      if (got == 1000) abort = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    n_chk++;
    if (got != 1000) begin
      n_fail++;
      $display("FAIL abort_reach got=%0d expected=1000", got);
    end
    @(negedge clk);
    abort = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle busy=%b valid=%b done=%b expected 0 0 0", busy, out_valid, done);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_done cyc=%0d done=%b valid=%b expected 0 0", i, done, out_valid);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    set_rand();
    fill_q();
    @(negedge clk);
    start = 1'b1;
    load_done = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_chk++;
    if (all_out !== '0) begin
      n_fail++;
      $display("FAIL reset_mid got=%h expected=0", all_out);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (all_out !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_after got=%h expected=0", all_out);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b1 || cur !== q[0]) begin
      n_fail++;
      $display("FAIL restart_first valid=%b got=%h expected valid=1 %h", out_valid, cur, q[0]);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_zeros();
    test_ones();
    test_corner_pixel();
    test_backpressure();
    test_wait_load_abort();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
